// File: rtl/pixel_rx_pkg.sv
// pixel_rx_pkg
//   Shared types for the pixel readout receiver: default bus/array sizes,
//   the capture FSM state encoding and the buffered sample record.
//   The sample record is sized from PIX_DW / PIX_NPIX, so the top-level
//   DW / NPIX parameters must be left at these defaults (or the package
//   values changed alongside them).
package pixel_rx_pkg;

    localparam int PIX_DW    = 8;
    localparam int PIX_NPIX  = 4;
    localparam int PIX_IDX_W = $clog2(PIX_NPIX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [PIX_DW-1:0]    data;
        logic [PIX_IDX_W-1:0] idx;
        logic                 last;
    } pix_entry_t;

    // True when exactly one bit of the read-select vector is set.
    function automatic logic is_onehot(input logic [PIX_NPIX-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/pixel_rx_fifo.sv
// pixel_rx_fifo
//   Synchronous FIFO of pix_entry_t samples.
//   Ports:
//     CLK, RESET   clock, asynchronous active-low reset
//     push         write push_entry (accepted if not full, or full with a pop)
//     push_entry   sample to store
//     pop          remove the head (ignored when empty)
//     head         head-of-FIFO entry, zero when empty
//     empty, full  occupancy flags
//     level        number of stored entries (0..FIFO_DEPTH)
//   A push into an empty FIFO becomes visible on head the following cycle;
//   there is no fall-through path from push_entry to head.
module pixel_rx_fifo
    import pixel_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        push,
    input  pix_entry_t                  push_entry,
    input  logic                        pop,
    output pix_entry_t                  head,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    pix_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push is about to use.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Gating keeps the outputs at zero while empty, including after reset.
    assign head  = empty ? '0 : mem[rd_ptr];
    assign level = level_q;

endmodule

// File: rtl/pixel_readout_rx.sv
// pixel_readout_rx
//   Receiving end of the pixel readout bus. Each READ strobe selects one
//   pixel which drives its code on DATA_BUS; the code is sampled SETTLE+1
//   cycles after the strobe rises, tagged with the pixel index and an
//   end-of-frame flag, and buffered for the downstream image pipeline.
//   Purely a bus listener: DATA_BUS is never driven.
//   Ports:
//     CLK, RESET   clock, asynchronous active-low reset
//     DATA_BUS     shared pixel bus (sampled)
//     READ         one-hot pixel read selects
//     CONVERT      conversion phase; rising edge starts a new frame
//     PIX_DATA/PIX_IDX/PIX_LAST/PIX_VALID/PIX_READY   output sample stream
//     FIFO_LEVEL   buffer occupancy
//     OVERFLOW     sticky: sample dropped because the buffer was full
//     READ_ERR     sticky: multi-bit READ, or strobe ended before sampling
//     ERR_CLR      clears both sticky flags (a coincident new error wins)
//     FRAME_CNT    completed frames, wrapping
//     RX_STATE     current capture FSM state
//   Stream handshake: PIX_VALID is high whenever the buffer holds a sample;
//   the head is consumed on any cycle with PIX_VALID && PIX_READY, and the
//   PIX_* values hold steady while PIX_VALID is high and PIX_READY is low.
module pixel_readout_rx
    import pixel_rx_pkg::*;
#(
    parameter int NPIX       = PIX_NPIX,
    parameter int DW         = PIX_DW,
    parameter int SETTLE     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DW-1:0]               DATA_BUS,
    input  logic [NPIX-1:0]             READ,
    input  logic                        CONVERT,
    output logic [DW-1:0]               PIX_DATA,
    output logic [$clog2(NPIX)-1:0]     PIX_IDX,
    output logic                        PIX_LAST,
    output logic                        PIX_VALID,
    input  logic                        PIX_READY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        OVERFLOW,
    output logic                        READ_ERR,
    input  logic                        ERR_CLR,
    output logic [15:0]                 FRAME_CNT,
    output rx_state_t                   RX_STATE
);

    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NPIX - 1);

    rx_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cap_cnt_q;
    logic [NPIX-1:0]  read_prev;
    logic             convert_prev;
    logic             overflow_q;
    logic             read_err_q;
    logic [15:0]      frame_cnt_q;

    logic             read_rise;
    logic             convert_rise;
    logic             capture;
    logic             err_evt;
    logic             cap_last;
    logic             drop;
    pix_entry_t       push_entry;
    pix_entry_t       head;
    logic             fifo_empty;
    logic             fifo_full;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NPIX-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign read_rise    = (READ != '0) && (read_prev == '0);
    assign convert_rise = CONVERT && !convert_prev;

    // Capture FSM: next state and control strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        capture = 1'b0;
        err_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_rise) begin
                    if (is_onehot(READ)) begin
                        idx_d   = onehot_to_idx(READ);
                        cnt_d   = 4'(SETTLE - 1);
                        state_d = WAIT;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Any change of the select before sampling means the bus
                // value can no longer be trusted for this pixel.
                if (READ != read_prev) begin
                    err_evt = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (READ == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cap_last   = (cap_cnt_q == LAST_CNT);
    assign push_entry = '{data: DATA_BUS, idx: idx_q, last: cap_last};
    // Full implies non-empty, so PIX_READY alone tells whether a pop frees a slot.
    assign drop       = capture && fifo_full && !PIX_READY;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            cap_cnt_q    <= '0;
            read_prev    <= '0;
            convert_prev <= 1'b0;
            overflow_q   <= 1'b0;
            read_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            read_prev    <= READ;
            convert_prev <= CONVERT;

            // Frame start takes priority over a coincident capture; the
            // capture still uses the old count for its LAST tag.
            if (convert_rise) begin
                cap_cnt_q <= '0;
            end else if (capture) begin
                cap_cnt_q <= cap_last ? '0 : cap_cnt_q + 1'b1;
            end

            // Frames are counted even when the final sample is dropped.
            if (capture && cap_last) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ERR_CLR) begin
                overflow_q <= 1'b0;
            end

            if (err_evt) begin
                read_err_q <= 1'b1;
            end else if (ERR_CLR) begin
                read_err_q <= 1'b0;
            end
        end
    end

    pixel_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (capture),
        .push_entry (push_entry),
        .pop        (PIX_READY),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .level      (FIFO_LEVEL)
    );

    assign PIX_DATA  = head.data;
    assign PIX_IDX   = head.idx;
    assign PIX_LAST  = head.last;
    assign PIX_VALID = !fifo_empty;
    assign OVERFLOW  = overflow_q;
    assign READ_ERR  = read_err_q;
    assign FRAME_CNT = frame_cnt_q;
    assign RX_STATE  = state_q;

endmodule

// File: doc/pixel_readout_rx.md
Name: pixel_readout_rx

Overview:
- Receiving end of the pixel readout bus.
- During each READ strobe, the selected pixel drives its latched 8-bit conversion code onto DATA_BUS. This block samples that code after a settle delay and tags it with the pixel index and end-of-frame flag.
- Captured samples are buffered in a small FIFO and presented on a valid/ready stream to the downstream image pipeline.
- Sits beside the pixel array and state controller. It is a bus listener only and never drives DATA_BUS.

Parameters:
- NPIX, 4: pixels per frame; READ width.
- DW, 8: pixel code width; DATA_BUS width.
- SETTLE, 2: cycles from READ rising to sample (1..15).
- FIFO_DEPTH, 4: sample buffer entries (power of 2, >=2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- DATA_BUS  in  DW  shared pixel bus, sampled only.
- READ  in  NPIX  pixel read selects, one-hot when active.
- CONVERT  in  1  conversion phase; a rising edge marks frame start.
- PIX_DATA  out  DW  head-of-FIFO pixel code.
- PIX_IDX  out  $clog2(NPIX)  head-of-FIFO pixel index.
- PIX_LAST  out  1  head entry is the NPIX-th capture of the frame.
- PIX_VALID  out  1  FIFO non-empty.
- PIX_READY  in  1  downstream accepts the head when PIX_VALID && PIX_READY.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  occupancy.
- OVERFLOW  out  1  sticky: a capture was dropped because the FIFO was full.
- READ_ERR  out  1  sticky: READ had more than one bit set, or a strobe ended before sampling.
- ERR_CLR  in  1  single-cycle clear of OVERFLOW and READ_ERR.
- FRAME_CNT  out  16  completed frames, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (RESET=0, asynchronous): FSM=IDLE; FIFO empty.
  - PIX_VALID=0, PIX_DATA=0, PIX_IDX=0, PIX_LAST=0, FIFO_LEVEL=0.
  - OVERFLOW=0, READ_ERR=0, FRAME_CNT=0, capture count=0.
  - All of the above also apply when reset is asserted mid-strobe or mid-frame; that partial frame is discarded.
- READ and CONVERT are registered once internally as edge references. DATA_BUS is sampled directly; SETTLE covers bus settling.
- FSM states:
  - IDLE: on a cycle where READ is non-zero and READ_prev==0:
    - READ one-hot -> latch the index -> WAIT, counter=SETTLE-1.
    - Otherwise set READ_ERR and stay in IDLE.
  - WAIT: counter decrements each cycle.
    - READ changes before the counter hits 0 -> set READ_ERR -> HOLD, no push.
    - Counter=0 -> CAPTURE.
  - CAPTURE (1 cycle): push {DATA_BUS, idx, last} -> HOLD.
    - last = (capture count==NPIX-1).
    - Count increments; on last, count resets to 0 and FRAME_CNT increments.
  - HOLD: wait for READ==0, then IDLE. A strobe held across many cycles produces exactly one sample.
- Latency: sample is taken SETTLE+1 cycles after the READ-rising cycle. It appears on the PIX_* outputs the cycle after CAPTURE if the FIFO was empty.
- Frame start: CONVERT rising edge resets the capture count to 0. Any partial frame already in the FIFO keeps its entries, and no LAST is emitted for it.
- FIFO:
  - Push when full and no pop in the same cycle -> drop the sample, set OVERFLOW; count and FRAME_CNT still advance.
  - Push and pop in the same cycle when full -> both succeed, level unchanged.
  - Push when empty -> visible next cycle; no fall-through.
  - PIX_* outputs are stable while PIX_VALID && !PIX_READY.
- Sticky flags: ERR_CLR clears them. If ERR_CLR coincides with a new error event, the set wins.
- FRAME_CNT wraps from 0xFFFF to 0.

Decomposition:
- Package pixel_rx_pkg holds:
  - DW and NPIX defaults;
  - rx_state_t enum (IDLE, WAIT, CAPTURE, HOLD);
  - pix_entry_t struct {data[DW], idx, last}.
- Sub-module pixel_rx_fifo: synchronous FIFO of pix_entry_t with level output, parameterised by FIFO_DEPTH, same CLK and active-low asynchronous RESET.

Test Plan:
- Four strobes READ=1000,0100,0010,0001, each 4 cycles, bus values 0x12,0x34,0x56,0x78, PIX_READY=1 -> four entries:
  - idx 3,2,1,0, data in order;
  - PIX_LAST only on 0x78;
  - FRAME_CNT=1.
- SETTLE=2, bus changes 0x00 -> 0xAA one cycle after READ rises -> captured value is 0xAA, never 0x00.
- PIX_READY=0, FIFO_DEPTH=4, 5 strobes -> FIFO_LEVEL=4, OVERFLOW=1, first 4 values retained. ERR_CLR pulse -> OVERFLOW=0.
- READ=0110 -> no push, READ_ERR=1. A 1-cycle strobe READ=0001 with SETTLE=2 -> READ_ERR=1, no push.
- Reset asserted (RESET=0) during WAIT after 2 of 4 captures -> all outputs return to reset values. Next full frame yields FRAME_CNT=1 with LAST on its 4th sample.
- CONVERT rising after 2 captures, then 4 strobes -> LAST on the 4th post-CONVERT sample. FRAME_CNT preset near 0xFFFF via repeated frames -> wraps to 0.
